// File: rtl/rand_host_requester.sv
// rand_host_requester
//   Host-side requester for the TRNG CPU random-number port. Accepts one
//   RDRAND/RDSEED command and issues a single-cycle rand_req. It then assembles
//   the returned OUTPUT_WIDTH-bit beats into a right-aligned 64-bit word and
//   returns that word as a one-cycle response. A per-beat idle timeout guards
//   against a stalled device. Beats arriving outside COLLECT are counted as
//   spurious.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = FSM idle)
//   cmd_type[2:0]              bit2: 0 RDRAND / 1 RDSEED; bits1:0: 16/32/64, 3 illegal
//   rand_req, rand_req_type    request strobe and type to the device
//   rand_byte, rand_valid      data slice from the device
//   resp_valid                 one-cycle response pulse
//   resp_data/type/error       response payload, held until the next response
//   spurious_cnt               saturating count of unexpected beats
//   busy                       FSM not idle
module rand_host_requester #(
  parameter int unsigned OUTPUT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_type,
  output logic                    rand_req,
  output logic [2:0]              rand_req_type,
  input  logic [OUTPUT_WIDTH-1:0] rand_byte,
  input  logic                    rand_valid,
  output logic                    resp_valid,
  output logic [63:0]             resp_data,
  output logic [2:0]              resp_type,
  output logic                    resp_error,
  output logic [7:0]              spurious_cnt,
  output logic                    busy
);

  localparam int unsigned SLICES = 64 / OUTPUT_WIDTH;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);
  // Beat counts round up so a 16-bit request on a 32-bit port still takes one beat.
  localparam logic [3:0] N16 = 4'((16 + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH);
  localparam logic [3:0] N32 = 4'((32 + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH);
  localparam logic [3:0] N64 = 4'(64 / OUTPUT_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      type_q, type_d;
  logic [3:0]      n_q, n_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [63:0]     asm_q, asm_d;
  logic            rand_req_q, rand_req_d;
  logic [2:0]      rand_req_type_q, rand_req_type_d;
  logic            resp_valid_q, resp_valid_d;
  logic [63:0]     resp_data_q, resp_data_d;
  logic [2:0]      resp_type_q, resp_type_d;
  logic            resp_error_q, resp_error_d;
  logic [7:0]      spurious_cnt_q, spurious_cnt_d;

  // Zero everything above the requested width (drops the upper half of a
  // 32-bit slice when a 16-bit request is served by a 32-bit port).
  function automatic logic [63:0] trim(input logic [63:0] d, input logic [1:0] w);
    case (w)
      2'd0:    trim = {48'd0, d[15:0]};
      2'd1:    trim = {32'd0, d[31:0]};
      default: trim = d;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    n_d             = n_q;
    beat_cnt_d      = beat_cnt_q;
    timer_d         = timer_q;
    asm_d           = asm_q;
    rand_req_d      = 1'b0;
    rand_req_type_d = rand_req_type_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = resp_data_q;
    resp_type_d     = resp_type_q;
    resp_error_d    = resp_error_q;
    spurious_cnt_d  = spurious_cnt_q;

    if (rand_valid && (state_q != S_COLLECT) && (spurious_cnt_q != 8'hFF))
      spurious_cnt_d = spurious_cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          type_d          = cmd_type;
          rand_req_type_d = cmd_type;
          asm_d           = '0;
          beat_cnt_d      = '0;
          timer_d         = '0;
          case (cmd_type[1:0])
            2'd0:    n_d = N16;
            2'd1:    n_d = N32;
            default: n_d = N64;
          endcase
          if (cmd_type[1:0] == 2'b11) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_type_d  = cmd_type;
            resp_error_d = 1'b1;
          end else begin
            state_d    = S_REQ;
            rand_req_d = 1'b1;
          end
        end
      end
      S_REQ: state_d = S_COLLECT;
      S_COLLECT: begin
        if (rand_valid) begin
          for (int unsigned s = 0; s < SLICES; s++)
            if (beat_cnt_q == 4'(s)) asm_d[s*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rand_byte;
          beat_cnt_d = beat_cnt_q + 4'd1;
          timer_d    = '0;
          if (beat_cnt_d == n_q) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = trim(asm_d, type_q[1:0]);
            resp_type_d  = type_q;
            resp_error_d = 1'b0;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = trim(asm_q, type_q[1:0]);
          resp_type_d  = type_q;
          resp_error_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d         = S_IDLE;
        rand_req_type_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      type_q          <= '0;
      n_q             <= '0;
      beat_cnt_q      <= '0;
      timer_q         <= '0;
      asm_q           <= '0;
      rand_req_q      <= 1'b0;
      rand_req_type_q <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_type_q     <= '0;
      resp_error_q    <= 1'b0;
      spurious_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      type_q          <= type_d;
      n_q             <= n_d;
      beat_cnt_q      <= beat_cnt_d;
      timer_q         <= timer_d;
      asm_q           <= asm_d;
      rand_req_q      <= rand_req_d;
      rand_req_type_q <= rand_req_type_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_type_q     <= resp_type_d;
      resp_error_q    <= resp_error_d;
      spurious_cnt_q  <= spurious_cnt_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rand_req      = rand_req_q;
  assign rand_req_type = rand_req_type_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_type     = resp_type_q;
  assign resp_error    = resp_error_q;
  assign spurious_cnt  = spurious_cnt_q;

endmodule

// File: tb/tb_rand_host_requester.sv
// Directed bench for rand_host_requester (OUTPUT_WIDTH 8, TIMEOUT_CYCLES 16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rand_host_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_type;
  logic        rand_req;
  logic [2:0]  rand_req_type;
  logic [7:0]  rand_byte;
  logic        rand_valid;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [2:0]  resp_type;
  logic        resp_error;
  logic [7:0]  spurious_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int resp_cnt = 0;

  rand_host_requester #(.OUTPUT_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .rand_req(rand_req), .rand_req_type(rand_req_type),
    .rand_byte(rand_byte), .rand_valid(rand_valid), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_type(resp_type), .resp_error(resp_error),
    .spurious_cnt(spurious_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rand_req)   req_cnt++;
    if (resp_valid) resp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t);
    cmd_valid = 1'b1;
    cmd_type  = t;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] b);
    rand_valid = 1'b1;
    rand_byte  = b;
    tick();
    rand_valid = 1'b0;
    rand_byte  = '0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cmd_ready"},  64'(cmd_ready), 64'd1);
    check({pfx, "_rand_req"},   64'(rand_req), 64'd0);
    check({pfx, "_req_type"},   64'(rand_req_type), 64'd0);
    check({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({pfx, "_resp_data"},  resp_data, 64'd0);
    check({pfx, "_resp_type"},  64'(resp_type), 64'd0);
    check({pfx, "_resp_error"}, 64'(resp_error), 64'd0);
    check({pfx, "_spurious"},   64'(spurious_cnt), 64'd0);
    check({pfx, "_busy"},       64'(busy), 64'd0);
  endtask

  initial begin
    int r0, q0, early;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_type = '0; rand_valid = 1'b0; rand_byte = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // RDRAND64: beats 01..08 start 3 cycles after rand_req (cycle 1 -> 4)
    r0 = req_cnt;
    issue(3'b010);
    check("r64_req", 64'(rand_req), 64'd1);
    check("r64_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    for (int i = 1; i <= 8; i++) beat(8'(i));
    check("r64_valid", 64'(resp_valid), 64'd1);
    check("r64_data", resp_data, 64'h0807060504030201);
    check("r64_type", 64'(resp_type), 64'd2);
    check("r64_err", 64'(resp_error), 64'd0);
    tick();
    check("r64_valid_drop", 64'(resp_valid), 64'd0);
    check("r64_ready_back", 64'(cmd_ready), 64'd1);
    check("r64_data_hold", resp_data, 64'h0807060504030201);
    check("r64_one_req", 64'(req_cnt - r0), 64'd1);

    // RDSEED16 with 5-cycle gap between beats
    issue(3'b100);
    check("s16_req_type_req", 64'(rand_req_type), 64'd4);
    tick();
    beat(8'hAA);
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (rand_req_type !== 3'b100 || resp_valid !== 1'b0) early++;
      tick();
    end
    check("s16_gap_hold", 64'(early), 64'd0);
    beat(8'h55);
    check("s16_valid", 64'(resp_valid), 64'd1);
    check("s16_data", resp_data, 64'h55AA);
    check("s16_type", 64'(resp_type), 64'd4);
    check("s16_req_type_done", 64'(rand_req_type), 64'd4);
    tick();
    check("s16_req_type_idle", 64'(rand_req_type), 64'd0);

    // RDRAND32 timeout after two beats (last beat cycle 3 -> response cycle 20)
    issue(3'b001);
    tick();
    beat(8'h11);
    beat(8'h22);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      if (resp_valid !== 1'b0) early++;
      tick();
    end
    check("to_no_early", 64'(early), 64'd0);
    check("to_valid", 64'(resp_valid), 64'd1);
    check("to_data", resp_data, 64'h2211);
    check("to_err", 64'(resp_error), 64'd1);
    check("to_type", 64'(resp_type), 64'd1);
    tick();

    // RDRAND16, no beats at all: response in cycle 2+16
    issue(3'b000);
    early = 0;
    for (int i = 0; i < 17; i++) begin
      if (resp_valid !== 1'b0) early++;
      tick();
    end
    check("to0_no_early", 64'(early), 64'd0);
    check("to0_valid", 64'(resp_valid), 64'd1);
    check("to0_data", resp_data, 64'd0);
    check("to0_err", 64'(resp_error), 64'd1);
    tick();

    // RDRAND32, first beat lands on the last timer cycle (cycle 17): beat wins
    issue(3'b001);
    tick();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      if (resp_valid !== 1'b0) early++;
      tick();
    end
    for (int i = 1; i <= 4; i++) beat(8'(8'hC0 + i));
    check("edge_no_early", 64'(early), 64'd0);
    check("edge_valid", 64'(resp_valid), 64'd1);
    check("edge_data", resp_data, 64'hC4C3C2C1);
    check("edge_err", 64'(resp_error), 64'd0);
    tick();

    // Illegal width code
    r0 = req_cnt;
    issue(3'b011);
    check("ill_valid", 64'(resp_valid), 64'd1);
    check("ill_err", 64'(resp_error), 64'd1);
    check("ill_data", resp_data, 64'd0);
    check("ill_type", 64'(resp_type), 64'd3);
    check("ill_rand_req", 64'(rand_req), 64'd0);
    tick();
    check("ill_no_req", 64'(req_cnt - r0), 64'd0);
    check("ill_ready", 64'(cmd_ready), 64'd1);

    // 300 spurious pulses in IDLE saturate at 255
    check("sp_start", 64'(spurious_cnt), 64'd0);
    q0 = resp_cnt;
    for (int i = 0; i < 300; i++) begin
      beat(8'hEE);
      tick();
      if (i == 99) check("sp_100", 64'(spurious_cnt), 64'd100);
    end
    check("sp_sat", 64'(spurious_cnt), 64'd255);
    check("sp_no_resp", 64'(resp_cnt - q0), 64'd0);
    issue(3'b000);
    tick();
    beat(8'h34);
    beat(8'h12);
    check("sp_r16_valid", 64'(resp_valid), 64'd1);
    check("sp_r16_data", resp_data, 64'h1234);
    check("sp_r16_err", 64'(resp_error), 64'd0);
    tick();

    // Reset in the middle of COLLECT
    q0 = resp_cnt;
    issue(3'b010);
    tick();
    beat(8'h91);
    beat(8'h92);
    beat(8'h93);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid");
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_no_resp", 64'(resp_cnt - q0), 64'd0);

    // Clean RDRAND32 after reset, then a stray beat in the DONE cycle
    issue(3'b001);
    tick();
    beat(8'hA1);
    beat(8'hA2);
    beat(8'hA3);
    beat(8'hA4);
    check("post_valid", 64'(resp_valid), 64'd1);
    check("post_data", resp_data, 64'hA4A3A2A1);
    check("post_err", 64'(resp_error), 64'd0);
    beat(8'hFF);
    check("done_spurious", 64'(spurious_cnt), 64'd1);
    check("done_data_hold", resp_data, 64'hA4A3A2A1);
    check("done_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
